// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the in-order core: per-stage valid tracking, stall/bubble
// generation, load-use/RAW hazard detection, EXE forwarding select, mul/div occupancy.
//
//   state | meaning
//   IDLE  | EXE free; a valid mul/div in EXE starts the occupancy count
//   BUSY  | mul/div occupying EXE; md_cnt cycles of stall remain
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int REG_ADDR_W = 5,
   parameter int LOAD_RDY   = 4,
   parameter bit FWD_EN     = 1'b1,
   parameter int MD_LAT     = 4,
   localparam int P         = NUM_STAGES - 2,
   localparam int SEL_W     = $clog2(P)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NUM_STAGES-1:0]   stall_req,
   input  logic                    redirect,
   input  logic [REG_ADDR_W-1:0]   id_rs,
   input  logic [REG_ADDR_W-1:0]   id_rt,
   input  logic                    id_uses_rs,
   input  logic                    id_uses_rt,
   input  logic [REG_ADDR_W-1:0]   ex_rs,
   input  logic [REG_ADDR_W-1:0]   ex_rt,
   input  logic [P*REG_ADDR_W-1:0] pw_addr,
   input  logic [P-1:0]            pw_en,
   input  logic [P-1:0]            p_load,
   input  logic                    md_start,
   output logic [NUM_STAGES-1:0]   stall,
   output logic [NUM_STAGES-1:0]   flush,
   output logic [NUM_STAGES-1:0]   valid,
   output logic [SEL_W-1:0]        fwd_a_sel,
   output logic [SEL_W-1:0]        fwd_b_sel
);

   localparam int MD_INIT = (MD_LAT > 1) ? MD_LAT - 2 : 0;
   localparam int CNT_W   = (MD_INIT > 1) ? $clog2(MD_INIT + 1) : 1;

   typedef enum logic {IDLE, BUSY} md_state_t;

   md_state_t             md_state;
   logic [CNT_W-1:0]      md_cnt;
   logic                  md_busy;
   logic                  hz_stall;
   logic                  hz_fwd;
   logic                  hz_raw;
   logic                  id_hit;
   logic [P-1:0]          live;
   logic [NUM_STAGES-1:0] stall_int;
   logic [NUM_STAGES-1:0] v;
   logic [SEL_W-1:0]      sel_a;
   logic [SEL_W-1:0]      sel_b;
   logic                  stall_acc;

   always_comb begin
      live = '0;
      for (int k = 0; k < P; k++) begin
         live[k] = v[k+2] & pw_en[k] & (pw_addr[k*REG_ADDR_W +: REG_ADDR_W] != '0);
      end
   end

   // With forwarding only loads too young to have data stall ID; without it any live writer does.
   always_comb begin
      hz_fwd = 1'b0;
      hz_raw = 1'b0;
      id_hit = 1'b0;
      for (int k = 0; k < P; k++) begin
         id_hit = (id_uses_rs && (pw_addr[k*REG_ADDR_W +: REG_ADDR_W] == id_rs)) ||
                  (id_uses_rt && (pw_addr[k*REG_ADDR_W +: REG_ADDR_W] == id_rt));
         if (live[k] && id_hit) begin
            hz_raw = 1'b1;
            if (p_load[k] && (k + 2 <= LOAD_RDY - 2)) hz_fwd = 1'b1;
         end
      end
      hz_stall = v[1] & (FWD_EN ? hz_fwd : hz_raw);
   end

   // Walk oldest to youngest so the youngest matching producer wins.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = P - 1; k >= 1; k--) begin
         if (live[k] && !(p_load[k] && (k + 2 < LOAD_RDY))) begin
            if (pw_addr[k*REG_ADDR_W +: REG_ADDR_W] == ex_rs) sel_a = SEL_W'(k);
            if (pw_addr[k*REG_ADDR_W +: REG_ADDR_W] == ex_rt) sel_b = SEL_W'(k);
         end
      end
   end

   assign fwd_a_sel = FWD_EN ? sel_a : '0;
   assign fwd_b_sel = FWD_EN ? sel_b : '0;

   always_comb begin
      if (md_state == IDLE) md_busy = md_start & v[2] & (MD_LAT > 1);
      else                  md_busy = (md_cnt != '0);
   end

   always_comb begin
      stall_int    = stall_req;
      stall_int[1] = stall_req[1] | hz_stall;
      stall_int[2] = stall_req[2] | md_busy;
      stall        = '0;
      stall_acc    = 1'b0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         stall_acc = stall_acc | stall_int[i];
         stall[i]  = stall_acc;
      end
   end

   always_comb begin
      flush = '0;
      for (int i = 1; i < NUM_STAGES; i++) begin
         flush[i] = stall[i-1] & ~stall[i];
      end
      flush[1] = flush[1] | (redirect & ~stall[1]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v <= '0;
      end else begin
         v[0] <= 1'b1;
         for (int i = 1; i < NUM_STAGES; i++) begin
            if (stall[i])      v[i] <= v[i];
            else if (flush[i]) v[i] <= 1'b0;
            else               v[i] <= v[i-1];
         end
      end
   end

   assign valid = v;

   // Leaving BUSY waits on stall[3] so a held mul/div is not restarted; stall[2] would loop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         md_state <= IDLE;
         md_cnt   <= '0;
      end else begin
         case (md_state)
            IDLE: begin
               if (md_busy) begin
                  md_cnt   <= CNT_W'(MD_INIT);
                  md_state <= BUSY;
               end
            end
            BUSY: begin
               if (md_cnt != '0)   md_cnt   <= md_cnt - CNT_W'(1);
               else if (!stall[3]) md_state <= IDLE;
            end
            default: md_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboarded directed bench for pipe_hazard_ctrl: one instance with forwarding,
// one without; expected stall/flush/valid/select values are hand-derived per vector.
module tb_pipe_hazard_ctrl;
   localparam int NS = 5;
   localparam int W  = 5;
   localparam int P  = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [NS-1:0]  stall_req;
   logic           redirect;
   logic [W-1:0]   id_rs, id_rt, ex_rs, ex_rt;
   logic           id_uses_rs, id_uses_rt;
   logic [P*W-1:0] pw_addr;
   logic [P-1:0]   pw_en, p_load;
   logic           md_start;

   logic [NS-1:0] stall1, flush1, valid1;
   logic [1:0]    fa1, fb1;
   logic [NS-1:0] stall0, flush0, valid0;
   logic [1:0]    fa0, fb0;

   pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_ADDR_W(W), .LOAD_RDY(4), .FWD_EN(1'b1), .MD_LAT(4)) dut (
      .clk(clk), .rstn(rstn), .stall_req(stall_req), .redirect(redirect),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .pw_addr(pw_addr), .pw_en(pw_en), .p_load(p_load),
      .md_start(md_start), .stall(stall1), .flush(flush1), .valid(valid1),
      .fwd_a_sel(fa1), .fwd_b_sel(fb1));

   pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_ADDR_W(W), .LOAD_RDY(4), .FWD_EN(1'b0), .MD_LAT(4)) dut0 (
      .clk(clk), .rstn(rstn), .stall_req(stall_req), .redirect(redirect),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .pw_addr(pw_addr), .pw_en(pw_en), .p_load(p_load),
      .md_start(md_start), .stall(stall0), .flush(flush0), .valid(valid0),
      .fwd_a_sel(fa0), .fwd_b_sel(fb0));

   typedef struct packed {
      logic       which;
      logic [4:0] st;
      logic [4:0] fl;
      logic [4:0] va;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   exp_t  cur;
   string cur_nm;
   int    total = 0;
   int    bad = 0;

   task automatic chk(input string nm, input string fld, input logic [4:0] act, input logic [4:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur    = exp_q.pop_front();
         cur_nm = name_q.pop_front();
         if (cur.which) begin
            chk(cur_nm, "stall", stall0, cur.st);
            chk(cur_nm, "flush", flush0, cur.fl);
            chk(cur_nm, "valid", valid0, cur.va);
            chk(cur_nm, "fwd_a", {3'b000, fa0}, {3'b000, cur.fa});
            chk(cur_nm, "fwd_b", {3'b000, fb0}, {3'b000, cur.fb});
         end else begin
            chk(cur_nm, "stall", stall1, cur.st);
            chk(cur_nm, "flush", flush1, cur.fl);
            chk(cur_nm, "valid", valid1, cur.va);
            chk(cur_nm, "fwd_a", {3'b000, fa1}, {3'b000, cur.fa});
            chk(cur_nm, "fwd_b", {3'b000, fb1}, {3'b000, cur.fb});
         end
      end
   end

   task automatic vec(input string nm, input logic which, input logic [4:0] st,
                      input logic [4:0] fl, input logic [4:0] va,
                      input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      e.which = which; e.st = st; e.fl = fl; e.va = va; e.fa = fa; e.fb = fb;
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge clk); #1;
   endtask

   task automatic clear_in();
      stall_req = '0; redirect = 1'b0;
      id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_rs = '0; ex_rt = '0;
      pw_addr = '0; pw_en = '0; p_load = '0; md_start = 1'b0;
   endtask

   task automatic set_pw(input int k, input logic [4:0] a, input logic en, input logic ld);
      pw_addr[k*W +: W] = a;
      pw_en[k]  = en;
      p_load[k] = ld;
   endtask

   task automatic fill(input logic which);
      rstn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
         vec("fill", which, 5'b00000, 5'b00000, 5'((1 << (i + 1)) - 1), 2'd0, 2'd0);
      end
   endtask

   initial begin
      #100000;
      bad++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      clear_in();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vec("reset", 1'b0, 5'b00000, 5'b00000, 5'b00000, 2'd0, 2'd0);
      fill(1'b0);

      // load-use: load in EXE, ID reads r8
      set_pw(0, 5'd8, 1'b1, 1'b1); id_rs = 5'd8; id_uses_rs = 1'b1;
      vec("lu_stall", 1'b0, 5'b00011, 5'b00100, 5'b11111, 2'd0, 2'd0);
      set_pw(0, 5'd0, 1'b0, 1'b0); set_pw(1, 5'd8, 1'b1, 1'b1); ex_rs = 5'd8;
      vec("lu_mem_excl", 1'b0, 5'b00000, 5'b00000, 5'b11011, 2'd0, 2'd0);
      set_pw(1, 5'd0, 1'b0, 1'b0); set_pw(2, 5'd8, 1'b1, 1'b1); id_uses_rs = 1'b0;
      vec("lu_fwd_wb", 1'b0, 5'b00000, 5'b00000, 5'b10111, 2'd2, 2'd0);

      clear_in();
      vec("refill", 1'b0, 5'b00000, 5'b00000, 5'b01111, 2'd0, 2'd0);
      set_pw(1, 5'd5, 1'b1, 1'b0); set_pw(2, 5'd5, 1'b1, 1'b0); ex_rs = 5'd5;
      vec("fwd_youngest", 1'b0, 5'b00000, 5'b00000, 5'b11111, 2'd1, 2'd0);
      set_pw(1, 5'd0, 1'b1, 1'b0);
      vec("fwd_r0", 1'b0, 5'b00000, 5'b00000, 5'b11111, 2'd2, 2'd0);
      set_pw(1, 5'd5, 1'b1, 1'b0); ex_rs = 5'd0; ex_rt = 5'd5;
      vec("fwd_b", 1'b0, 5'b00000, 5'b00000, 5'b11111, 2'd0, 2'd1);
      clear_in(); set_pw(0, 5'd7, 1'b1, 1'b0); id_rs = 5'd7; id_uses_rs = 1'b1;
      vec("alu_no_stall", 1'b0, 5'b00000, 5'b00000, 5'b11111, 2'd0, 2'd0);

      // mul/div occupies EXE for MD_LAT-1 stall cycles
      clear_in(); md_start = 1'b1;
      vec("md0", 1'b0, 5'b00111, 5'b01000, 5'b11111, 2'd0, 2'd0);
      vec("md1", 1'b0, 5'b00111, 5'b01000, 5'b10111, 2'd0, 2'd0);
      vec("md2", 1'b0, 5'b00111, 5'b01000, 5'b00111, 2'd0, 2'd0);
      stall_req = 5'b01000;
      vec("md_hold", 1'b0, 5'b01111, 5'b10000, 5'b00111, 2'd0, 2'd0);
      stall_req = 5'b00000;
      vec("md_no_restart", 1'b0, 5'b00000, 5'b00000, 5'b00111, 2'd0, 2'd0);
      md_start = 1'b0;
      vec("md_after", 1'b0, 5'b00000, 5'b00000, 5'b01111, 2'd0, 2'd0);

      // downstream stall dominates redirect
      stall_req = 5'b01000; redirect = 1'b1;
      vec("stall_vs_redir", 1'b0, 5'b01111, 5'b10000, 5'b11111, 2'd0, 2'd0);
      stall_req = 5'b00000;
      vec("redir", 1'b0, 5'b00000, 5'b00010, 5'b01111, 2'd0, 2'd0);
      redirect = 1'b0;
      vec("redir_post", 1'b0, 5'b00000, 5'b00000, 5'b11101, 2'd0, 2'd0);

      // no-forwarding instance: stall on any RAW until producer leaves WB
      clear_in();
      rstn = 1'b0;
      vec("reset_nofwd", 1'b1, 5'b00000, 5'b00000, 5'b00000, 2'd0, 2'd0);
      fill(1'b1);
      set_pw(1, 5'd3, 1'b1, 1'b0); id_rt = 5'd3; id_uses_rt = 1'b1; ex_rs = 5'd3;
      vec("raw_mem", 1'b1, 5'b00011, 5'b00100, 5'b11111, 2'd0, 2'd0);
      set_pw(1, 5'd0, 1'b0, 1'b0); set_pw(2, 5'd3, 1'b1, 1'b0);
      vec("raw_wb", 1'b1, 5'b00011, 5'b00100, 5'b11011, 2'd0, 2'd0);
      set_pw(2, 5'd0, 1'b0, 1'b0);
      vec("raw_clear", 1'b1, 5'b00000, 5'b00000, 5'b10011, 2'd0, 2'd0);

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
